// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-style SDRAM command port among NP
// burst requesters. One fixed-length burst (BL beats) is granted at a time,
// beat addresses are generated by incrementing from the latched start
// address, and read returns are steered back to their issuer through an
// in-order tag FIFO.
// Build option: SDRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0
// highest) instead of round-robin.

// Per-port slice: eligibility and the one-hot decode of grant, write ack and
// read-return ownership for one requester.
module sdram_port_arbiter_lane #(
  parameter int             PW = 2,
  parameter logic [PW-1:0]  ID = '0
) (
  input  logic          req,
  input  logic          req_wr,
  input  logic          tag_full,
  input  logic          xfer,
  input  logic          beat_acc,
  input  logic          win_wr,
  input  logic [PW-1:0] win_id,
  input  logic          ret_ok,
  input  logic [PW-1:0] head_id,
  output logic          elig,
  output logic          gnt,
  output logic          wr_ack,
  output logic          rd_hit
);
  // Reads need a free tag slot; writes only need the request.
  assign elig   = req & (req_wr | ~tag_full);
  assign gnt    = xfer & (win_id == ID);
  assign wr_ack = beat_acc & win_wr & (win_id == ID);
  assign rd_hit = ret_ok & (head_id == ID);
endmodule

module sdram_port_arbiter #(
  parameter int NP        = 3,
  parameter int BL        = 256,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NP-1:0]     req,
  input  logic [NP-1:0]     req_wr,
  input  logic [NP*24-1:0]  req_addr,
  input  logic [NP*16-1:0]  req_wrdata,
  output logic [NP-1:0]     gnt,
  output logic [NP-1:0]     wr_ack,
  output logic [15:0]       rd_data,
  output logic [NP-1:0]     rd_vld,
  output logic              err_orphan,
  output logic              avm_write,
  output logic              avm_read,
  output logic [23:0]       avm_addr,
  output logic [15:0]       avm_wrdata,
  input  logic [15:0]       avs_rddata,
  input  logic              avs_rddata_vld,
  input  logic              avs_waitrequest
);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam int BW = (BL > 1) ? $clog2(BL) : 1;
  localparam int TW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                    state, state_nxt;
  logic [NP-1:0][23:0]       addr_v;
  logic [NP-1:0][15:0]       wdat_v;
  logic [NP-1:0]             elig, rd_hit;
  logic                      found;
  logic [PW-1:0]             pick;
  logic [PW-1:0]             win_id;
  logic                      win_wr;
  logic [23:0]               base_addr;
  logic [BW-1:0]             beat_cnt;
  logic                      xfer, beat_acc, last_beat;

  logic [TAG_DEPTH-1:0][PW-1:0] tag_mem;
  logic [TW-1:0]             tag_wp, tag_rp;
  logic [CW-1:0]             tag_cnt;
  logic                      tag_full, tag_empty;
  logic                      push, pop, ret_ok;
  logic [BW-1:0]             ret_cnt;
  logic [PW-1:0]             head_id;

  // Unpack the flat per-port buses and instantiate per-port decode.
  for (genvar p = 0; p < NP; p++) begin : g_port
    assign addr_v[p] = req_addr[p*24 +: 24];
    assign wdat_v[p] = req_wrdata[p*16 +: 16];
    sdram_port_arbiter_lane #(.PW(PW), .ID(PW'(p))) u_lane (
      .req      (req[p]),
      .req_wr   (req_wr[p]),
      .tag_full (tag_full),
      .xfer     (xfer),
      .beat_acc (beat_acc),
      .win_wr   (win_wr),
      .win_id   (win_id),
      .ret_ok   (ret_ok),
      .head_id  (head_id),
      .elig     (elig[p]),
      .gnt      (gnt[p]),
      .wr_ack   (wr_ack[p]),
      .rd_hit   (rd_hit[p])
    );
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-numbered eligible port wins (scan high to low so
  // the last hit is the lowest index).
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        pick  = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr;
  logic [PW:0]   rr_sum;
  logic [PW-1:0] rr_idx;

  // Round-robin: first eligible port scanning upward from rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = 0; i < NP; i++) begin
      rr_sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (rr_sum >= (PW+1)'(NP)) rr_sum = rr_sum - (PW+1)'(NP);
      rr_idx = rr_sum[PW-1:0];
      if (!found && elig[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
  end

  // The port after the one just served starts the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             rr_ptr <= '0;
    else if (state == DONE) rr_ptr <= (win_id == PW'(NP - 1)) ? '0 : win_id + 1'b1;
  end
`endif

  assign xfer      = (state == XFER);
  assign beat_acc  = xfer & ~avs_waitrequest;
  assign last_beat = (beat_cnt == BW'(BL - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and command-port outputs (active-low commands).
  always_comb begin
    state_nxt  = state;
    avm_write  = 1'b1;
    avm_read   = 1'b1;
    avm_addr   = base_addr + 24'(beat_cnt);
    avm_wrdata = wdat_v[win_id];
    case (state)
      IDLE: if (found) state_nxt = XFER;
      XFER: begin
        avm_write = ~win_wr;
        avm_read  = win_wr;
        if (beat_acc && last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner at grant; step the beat counter on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_id    <= '0;
      win_wr    <= 1'b0;
      base_addr <= '0;
      beat_cnt  <= '0;
    end else if (state == IDLE && found) begin
      win_id    <= pick;
      win_wr    <= req_wr[pick];
      base_addr <= addr_v[pick];
      beat_cnt  <= '0;
    end else if (beat_acc) begin
      beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  assign tag_full  = (tag_cnt == CW'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign head_id   = tag_mem[tag_rp];
  assign push      = (state == IDLE) & found & ~req_wr[pick];
  assign ret_ok    = avs_rddata_vld & ~tag_empty;
  assign pop       = ret_ok & (ret_cnt == BW'(BL - 1));

  // In-order tag FIFO of read-burst owners; push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem <= '0;
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[tag_wp] <= pick;
        tag_wp <= (tag_wp == TW'(TAG_DEPTH - 1)) ? '0 : tag_wp + 1'b1;
      end
      if (pop) tag_rp <= (tag_rp == TW'(TAG_DEPTH - 1)) ? '0 : tag_rp + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Return path: count beats of the head burst, register data and owner,
  // and flag returns that arrive with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_cnt    <= '0;
      rd_data    <= '0;
      rd_vld     <= '0;
      err_orphan <= 1'b0;
    end else begin
      rd_vld <= rd_hit;
      if (ret_ok) begin
        rd_data <= avs_rddata;
        ret_cnt <= pop ? '0 : ret_cnt + 1'b1;
      end
      if (avs_rddata_vld && tag_empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter (NP=3, BL=4, TAG_DEPTH=4).
// Reference model: round-robin pointer, queue of outstanding read owners,
// return beat count and orphan flag, all kept as plain bench variables.
module tb_sdram_port_arbiter;
  localparam int NP = 3;
  localparam int BL = 4;
  localparam int TD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req, req_wr;
  logic [NP*24-1:0]  req_addr;
  logic [NP*16-1:0]  req_wrdata;
  logic [NP-1:0]     gnt, wr_ack, rd_vld;
  logic [15:0]       rd_data;
  logic              err_orphan, avm_write, avm_read;
  logic [23:0]       avm_addr;
  logic [15:0]       avm_wrdata, avs_rddata;
  logic              avs_rddata_vld, avs_waitrequest;

  int checks = 0;
  int errors = 0;
  int m_rr = 0;
  int tag_q[$];
  int m_ret = 0;
  bit m_orphan = 1'b0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NP(NP), .BL(BL), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wrdata(req_wrdata), .gnt(gnt), .wr_ack(wr_ack), .rd_data(rd_data),
    .rd_vld(rd_vld), .err_orphan(err_orphan), .avm_write(avm_write),
    .avm_read(avm_read), .avm_addr(avm_addr), .avm_wrdata(avm_wrdata),
    .avs_rddata(avs_rddata), .avs_rddata_vld(avs_rddata_vld),
    .avs_waitrequest(avs_waitrequest)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Arbitration rule applied to a request mask.
  function automatic int pick(input logic [NP-1:0] m);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NP; i++) if (m[i]) return i;
`else
    for (int i = 0; i < NP; i++) if (m[(m_rr + i) % NP]) return (m_rr + i) % NP;
`endif
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wrdata = '0;
    avs_rddata = '0; avs_rddata_vld = 1'b0; avs_waitrequest = 1'b0;
    #23;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
    checks++; if (wr_ack !== '0) begin errors++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
    checks++; if (rd_vld !== '0 || rd_data !== '0) begin errors++; $display("FAIL reset_rd got %b/%h want 0/0", rd_vld, rd_data); end
    checks++; if (avm_addr !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", avm_addr); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b want 0", err_orphan); end
    checks++; if ({avm_write, avm_read} !== 2'b11) begin errors++; $display("FAIL reset_cmd got %b want 11", {avm_write, avm_read}); end
    tick();
    rst_n = 1'b1;
  endtask

  // One burst from a lone requester, checked beat by beat from the IDLE cycle.
  task automatic do_burst(input int p, input bit wr, input logic [23:0] base,
                          input int stall_beat, input int stall_len, input bit rnd_stall);
    logic [15:0]   words [BL];
    logic [NP-1:0] oh;
    logic [23:0]   ea;
    int beat, stalled, cyc, acks;
    bit st;
    oh = NP'(1) << p;
    foreach (words[i]) words[i] = 16'($urandom);
    tick();
    req[p] = 1'b1; req_wr[p] = wr; req_addr[p*24 +: 24] = base;
    req_wrdata[p*16 +: 16] = words[0]; avs_waitrequest = 1'b0;
    tick();
    req[p] = 1'b0;
    checks++; if (gnt !== oh) begin errors++; $display("FAIL burst_gnt port %0d got %b want %b", p, gnt, oh); end
    beat = 0; stalled = 0; cyc = 0; acks = 0;
    while (beat < BL && cyc < 8 * BL) begin
      st = rnd_stall ? ($urandom_range(0, 3) == 0) : (beat == stall_beat && stalled < stall_len);
      avs_waitrequest = st;
      #1;
      ea = base + 24'(beat);
      checks++; if (avm_addr !== ea) begin errors++; $display("FAIL burst_addr beat %0d got %h want %h", beat, avm_addr, ea); end
      checks++; if ({avm_write, avm_read} !== (wr ? 2'b01 : 2'b10)) begin errors++; $display("FAIL burst_cmd beat %0d got %b want %b", beat, {avm_write, avm_read}, wr ? 2'b01 : 2'b10); end
      checks++; if (gnt !== oh) begin errors++; $display("FAIL burst_gnt_hold beat %0d got %b want %b", beat, gnt, oh); end
      checks++; if (wr_ack !== ((wr && !st) ? oh : NP'(0))) begin errors++; $display("FAIL burst_wr_ack beat %0d got %b want %b", beat, wr_ack, (wr && !st) ? oh : NP'(0)); end
      if (wr) begin
        checks++; if (avm_wrdata !== words[beat]) begin errors++; $display("FAIL burst_wrdata beat %0d got %h want %h", beat, avm_wrdata, words[beat]); end
      end
      if (wr_ack[p]) acks++;
      tick();
      cyc++;
      if (!st) begin
        beat++;
        if (beat < BL) req_wrdata[p*16 +: 16] = words[beat];
      end else stalled++;
    end
    avs_waitrequest = 1'b0;
    checks++; if (beat != BL) begin errors++; $display("FAIL burst_timeout beats %0d want %0d", beat, BL); end
    #1;
    checks++; if ({gnt, avm_write, avm_read} !== {NP'(0), 2'b11}) begin errors++; $display("FAIL burst_done got gnt %b cmd %b want 0 11", gnt, {avm_write, avm_read}); end
    if (wr) begin
      checks++; if (acks != BL) begin errors++; $display("FAIL burst_ack_count got %0d want %0d", acks, BL); end
    end
    if (!wr) tag_q.push_back(p);
    m_rr = (p + 1) % NP;
  endtask

  // Drive n return beats; each is checked one cycle later against the model.
  task automatic drive_returns(input int n, input bit gaps);
    logic [15:0]   d;
    logic [NP-1:0] exp;
    int own;
    for (int b = 0; b < n; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        avs_rddata_vld = 1'b0;
        tick();
        checks++; if (rd_vld !== '0) begin errors++; $display("FAIL ret_idle got %b want 0", rd_vld); end
      end
      d = 16'($urandom); avs_rddata = d; avs_rddata_vld = 1'b1;
      own = (tag_q.size() > 0) ? tag_q[0] : -1;
      if (own >= 0) begin
        m_ret++;
        if (m_ret == BL) begin void'(tag_q.pop_front()); m_ret = 0; end
      end else m_orphan = 1'b1;
      tick();
      exp = (own >= 0) ? (NP'(1) << own) : NP'(0);
      checks++; if (rd_vld !== exp) begin errors++; $display("FAIL ret_vld beat %0d got %b want %b", b, rd_vld, exp); end
      if (own >= 0) begin
        checks++; if (rd_data !== d) begin errors++; $display("FAIL ret_data beat %0d got %h want %h", b, rd_data, d); end
      end
      checks++; if (err_orphan !== m_orphan) begin errors++; $display("FAIL ret_orphan got %b want %b", err_orphan, m_orphan); end
    end
    avs_rddata_vld = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] prev;
    int got, exp, cyc;
    tick();
    for (int p = 0; p < NP; p++) begin
      req_addr[p*24 +: 24] = 24'($urandom);
      req_wrdata[p*16 +: 16] = 16'($urandom);
    end
    req = '1; req_wr = '1; avs_waitrequest = 1'b0;
    prev = '0; got = 0; cyc = 0;
    while (got < 4 && cyc < 20 * BL) begin
      tick(); cyc++;
      if (gnt !== '0 && prev === '0) begin
        exp = pick('1);
        checks++; if (gnt !== (NP'(1) << exp)) begin errors++; $display("FAIL rr_order grant %0d got %b want %b", got, gnt, NP'(1) << exp); end
        m_rr = (exp + 1) % NP;
        got++;
        if (got == 4) req = '0;
      end
      prev = gnt;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL rr_timeout grants %0d want 4", got); end
    cyc = 0;
    while (gnt !== '0 && cyc < 4 * BL) begin tick(); cyc++; end
    tick();
  endtask

  task automatic test_reads();
    do_burst(2, 1'b0, 24'($urandom), -1, 0, 1'b0);
    do_burst(1, 1'b0, 24'($urandom), -1, 0, 1'b1);
    repeat (10) tick();
    drive_returns(2 * BL, 1'b0);
  endtask

  task automatic test_tag_full();
    int cyc, blocked;
    for (int k = 0; k < TD; k++) do_burst($urandom_range(0, NP - 1), 1'b0, 24'($urandom), -1, 0, 1'b0);
    tick();
    req[0] = 1'b1; req_wr[0] = 1'b0; req_addr[23:0] = 24'($urandom);
    req[1] = 1'b1; req_wr[1] = 1'b1; req_addr[47:24] = 24'($urandom); req_wrdata[31:16] = 16'($urandom);
    tick();
    checks++; if (gnt !== NP'(2)) begin errors++; $display("FAIL full_write_gnt got %b want %b", gnt, NP'(2)); end
    req[1] = 1'b0; m_rr = 2;
    cyc = 0;
    while (gnt !== '0 && cyc < 4 * BL) begin tick(); cyc++; end
    blocked = 0;
    repeat (8) begin tick(); if (gnt !== '0) blocked++; end
    checks++; if (blocked != 0) begin errors++; $display("FAIL full_read_blocked granted cycles %0d want 0", blocked); end
    drive_returns(BL, 1'b0);
    cyc = 0;
    while (gnt === '0 && cyc < 8) begin tick(); cyc++; end
    checks++; if (gnt !== NP'(1)) begin errors++; $display("FAIL full_read_gnt got %b want %b", gnt, NP'(1)); end
    req[0] = 1'b0; tag_q.push_back(0); m_rr = 1;
    cyc = 0;
    while (gnt !== '0 && cyc < 4 * BL) begin tick(); cyc++; end
    tick();
    drive_returns(tag_q.size() * BL, 1'b1);
  endtask

  task automatic test_orphan_wrap();
    drive_returns(1, 1'b0);
    do_burst(1, 1'b1, 24'hFFFFFE, -1, 0, 1'b0);
    do_burst(0, 1'b0, 24'hFFFFFE, -1, 0, 1'b1);
    tick();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b want 1", err_orphan); end
    drive_returns(BL, 1'b1);
  endtask

  task automatic test_random();
    int p;
    bit wr;
    repeat (8) begin
      p  = $urandom_range(0, NP - 1);
      wr = (tag_q.size() >= TD) ? 1'b1 : 1'($urandom_range(0, 1));
      do_burst(p, wr, 24'($urandom), -1, 0, 1'b1);
    end
    drive_returns(tag_q.size() * BL, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    do_burst(1, 1'b0, 24'($urandom), -1, 0, 1'b0);
    tick();
    req[2] = 1'b1; req_wr[2] = 1'b1; req_addr[71:48] = 24'($urandom);
    tick();
    req[2] = 1'b0;
    repeat (2) tick();
    checks++; if (gnt !== NP'(4)) begin errors++; $display("FAIL midrst_pre_gnt got %b want %b", gnt, NP'(4)); end
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== '0 || {avm_write, avm_read} !== 2'b11) begin errors++; $display("FAIL midrst_cmd got gnt %b cmd %b want 0 11", gnt, {avm_write, avm_read}); end
    checks++; if (avm_addr !== '0 || err_orphan !== 1'b0) begin errors++; $display("FAIL midrst_regs got addr %h orphan %b want 0 0", avm_addr, err_orphan); end
    tag_q.delete(); m_rr = 0; m_ret = 0; m_orphan = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_returns(2, 1'b0);
    do_burst(0, 1'b1, 24'($urandom), -1, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    do_burst(0, 1'b1, 24'h000100, -1, 0, 1'b0);
    do_burst(0, 1'b1, 24'h000200, 2, 3, 1'b0);
    test_reads();
    test_tag_full();
    test_orphan_wrap();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
